// File: rtl/pe_array_pkg.sv
// ---------------------------------------------------------------------------
// pe_array_pkg: shared widths, limits and state encoding for the PE array
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pe_array_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } psum_state_t;

   localparam int MAX_PASSES      = 16;
   localparam int accumulationPar = 32;
   localparam int weightPar       = 8;

endpackage

`default_nettype wire

// File: rtl/psum_accumulator_if.sv
// ---------------------------------------------------------------------------
// psum_accumulator_if: job config, psum input and activation output bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface psum_accumulator_if #(
   parameter int DEPTH           = 16,
   parameter int accumulationPar = pe_array_pkg::accumulationPar,
   parameter int weightPar       = pe_array_pkg::weightPar
);
   localparam int AW = $clog2(DEPTH);

   logic                       start;
   logic [AW:0]                cfg_len;
   logic [4:0]                 cfg_passes;
   logic [4:0]                 cfg_shift;
   logic                       in_valid;
   logic [accumulationPar-1:0] inPartialSum;
   logic                       out_valid;
   logic                       out_ready;
   logic [weightPar-1:0]       out_data;
   logic                       out_last;
   logic                       busy;
   logic                       done;
   logic                       drop;

   modport master (
      output start, cfg_len, cfg_passes, cfg_shift, in_valid, inPartialSum, out_ready,
      input  out_valid, out_data, out_last, busy, done, drop
   );

   modport slave (
      input  start, cfg_len, cfg_passes, cfg_shift, in_valid, inPartialSum, out_ready,
      output out_valid, out_data, out_last, busy, done, drop
   );

endinterface

`default_nettype wire

// File: rtl/psum_accumulator_requant.sv
// ---------------------------------------------------------------------------
// psum_requant: ReLU, arithmetic right shift and positive saturation
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psum_requant #(
   parameter int accumulationPar = pe_array_pkg::accumulationPar,
   parameter int weightPar       = pe_array_pkg::weightPar
) (
   input  logic [accumulationPar-1:0] value,
   input  logic [4:0]                 shift,
   output logic [weightPar-1:0]       result
);

   localparam logic [accumulationPar-1:0] c_q_max =
      accumulationPar'((1 << (weightPar - 1)) - 1);

   logic [accumulationPar-1:0] w_shifted;

   // Negative inputs are zeroed first, so a logical shift is safe here.
   always_comb begin
      w_shifted = value >> shift;
      if (value[accumulationPar-1]) begin
         result = '0;
      end else if (w_shifted > c_q_max) begin
         result = c_q_max[weightPar-1:0];
      end else begin
         result = w_shifted[weightPar-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator: multi-pass partial-sum buffer drained through requant
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psum_accumulator #(
   parameter int accumulationPar = pe_array_pkg::accumulationPar,
   parameter int weightPar       = pe_array_pkg::weightPar,
   parameter int DEPTH           = 16
) (
   input  logic                clk,
   input  logic                rst,
   psum_accumulator_if.slave   bus
);
   import pe_array_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_depth      = (AW + 1)'(DEPTH);
   localparam logic [4:0]  c_max_passes = 5'(MAX_PASSES);

   psum_state_t                r_state;
   logic [accumulationPar-1:0] r_buf [DEPTH];
   logic [AW:0]                r_len;
   logic [4:0]                 r_passes;
   logic [4:0]                 r_shift;
   logic [4:0]                 r_pass;
   logic [AW-1:0]              r_idx;
   logic [AW-1:0]              r_ridx;
   logic                       r_out_valid;
   logic [weightPar-1:0]       r_out_data;
   logic                       r_out_last;
   logic                       r_done;
   logic                       r_drop;

   logic                       w_cfg_ok;
   logic                       w_beat;
   logic [AW:0]                w_len_m1;
   logic                       w_idx_wrap;
   logic                       w_last_beat;
   logic                       w_hs;
   logic [accumulationPar-1:0] w_wdata;
   logic [AW-1:0]              w_raddr;
   logic [accumulationPar-1:0] w_rdata;
   logic [weightPar-1:0]       w_rq;

   assign w_cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= c_depth) &&
                        (bus.cfg_passes != '0) && (bus.cfg_passes <= c_max_passes);
   assign w_beat      = (r_state == ACCUM) && bus.in_valid;
   assign w_len_m1    = r_len - 1'b1;
   assign w_idx_wrap  = ({1'b0, r_idx} == w_len_m1);
   assign w_last_beat = w_beat && w_idx_wrap && (r_pass == r_passes - 5'd1);
   assign w_hs        = r_out_valid && bus.out_ready;

   // Pass 0 overwrites, so stale contents from an earlier job never leak in.
   assign w_wdata = (r_pass == '0) ? bus.inPartialSum : r_buf[r_idx] + bus.inPartialSum;

   // Next entry to present; forwarding the in-flight write lets a one-entry
   // job present its result in the cycle right after the final beat.
   assign w_raddr = (r_state == ACCUM) ? '0 : r_ridx + 1'b1;
   assign w_rdata = (w_beat && (r_idx == w_raddr)) ? w_wdata : r_buf[w_raddr];

   psum_requant #(
      .accumulationPar (accumulationPar),
      .weightPar       (weightPar)
   ) u_requant (
      .value  (w_rdata),
      .shift  (r_shift),
      .result (w_rq)
   );

   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_buf[r_idx] <= w_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_passes    <= '0;
         r_shift     <= '0;
         r_pass      <= '0;
         r_idx       <= '0;
         r_ridx      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_drop <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_drop <= 1'b1;
               end
               if (bus.start && w_cfg_ok) begin
                  r_len    <= bus.cfg_len;
                  r_passes <= bus.cfg_passes;
                  r_shift  <= bus.cfg_shift;
                  r_idx    <= '0;
                  r_pass   <= '0;
                  r_state  <= ACCUM;
               end
            end
            ACCUM: begin
               if (w_beat) begin
                  if (w_idx_wrap) begin
                     r_idx  <= '0;
                     r_pass <= r_pass + 5'd1;
                  end else begin
                     r_idx  <= r_idx + 1'b1;
                  end
                  if (w_last_beat) begin
                     r_state     <= DRAIN;
                     r_ridx      <= '0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_rq;
                     r_out_last  <= (w_len_m1 == '0);
                  end
               end
            end
            DRAIN: begin
               if (bus.in_valid) begin
                  r_drop <= 1'b1;
               end
               if (w_hs) begin
                  if (r_out_last) begin
                     r_state     <= IDLE;
                     r_out_valid <= 1'b0;
                     r_out_data  <= '0;
                     r_out_last  <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_ridx      <= r_ridx + 1'b1;
                     r_out_data  <= w_rq;
                     r_out_last  <= ({1'b0, w_raddr} == w_len_m1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = r_done;
   assign bus.drop      = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator: scoreboard bench for psum_accumulator
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_psum_accumulator;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   psum_accumulator_if #(.DEPTH(16)) bus();

   psum_accumulator #(
      .accumulationPar (32),
      .weightPar       (8),
      .DEPTH           (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rq(input logic [31:0] v, input int sh);
      logic signed [31:0] s;
      s = v;
      if (s < 0) return 8'd0;
      s = s >>> sh;
      if (s > 127) return 8'd127;
      return s[7:0];
   endfunction

   task automatic start_job(input int len, input int passes, input int shift);
      bus.start      = 1'b1;
      bus.cfg_len    = 5'(len);
      bus.cfg_passes = 5'(passes);
      bus.cfg_shift  = 5'(shift);
      step();
      bus.start      = 1'b0;
   endtask

   // Feeds len*passes beats (pass-major) and pushes the expected drain sequence.
   task automatic feed_job(input int len, input int passes, input int shift,
                           input logic [31:0] vals[$], input int gap);
      logic [31:0] sums [16];
      exp_t        e;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < len; i++) begin
            logic [31:0] v;
            v = vals[p * len + i];
            sums[i] = (p == 0) ? v : sums[i] + v;
            bus.in_valid     = 1'b1;
            bus.inPartialSum = v;
            step();
            bus.in_valid     = 1'b0;
            if (!(p == passes - 1 && i == len - 1)) repeat (gap) step();
         end
      end
      for (int i = 0; i < len; i++) begin
         e.d = rq(sums[i], shift);
         e.l = (i == len - 1);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input int stall_at, input int stall_len);
      int         n = 0;
      int         guard = 0;
      int         stalled = 0;
      logic [7:0] hd = 8'd0;
      logic       hl = 1'b0;
      exp_t       e;
      bus.out_ready = 1'b1;
      while (sb.size() > 0 && guard < 300) begin
         guard++;
         if (bus.out_valid === 1'b1) begin
            if (n == stall_at && stalled < stall_len) begin
               if (stalled == 0) begin
                  hd = bus.out_data;
                  hl = bus.out_last;
               end else begin
                  total++;
                  if (bus.out_data !== hd || bus.out_last !== hl) begin
                     bad++;
                     $display("FAIL hold[%0d]: data=%0d last=%b required data=%0d last=%b",
                              n, bus.out_data, bus.out_last, hd, hl);
                  end
               end
               bus.out_ready = 1'b0;
               stalled++;
            end else begin
               bus.out_ready = 1'b1;
               e = sb.pop_front();
               total++;
               if (bus.out_data !== e.d || bus.out_last !== e.l) begin
                  bad++;
                  $display("FAIL out[%0d]: data=%0d last=%b required data=%0d last=%b",
                           n, bus.out_data, bus.out_last, e.d, e.l);
               end
               n++;
            end
         end
         step();
      end
      total++;
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
         sb.delete();
      end else if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL done: done=%b busy=%b out_valid=%b required 1 0 0",
                  bus.done, bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
      total++;
      if (bus.out_data !== 8'd0) begin bad++; $display("FAIL rst_out_data: got %0d required 0", bus.out_data); end
      total++;
      if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
      total++;
      if (bus.done !== 1'b0 || bus.drop !== 1'b0) begin
         bad++; $display("FAIL rst_done_drop: got %b %b required 0 0", bus.done, bus.drop);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_pass();
      logic [31:0] q[$];
      q = {32'd5, -32'sd3, 32'd200, 32'd127};
      start_job(4, 1, 0);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b required 1", bus.busy); end
      feed_job(4, 1, 0, q, 0);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd5) begin
         bad++; $display("FAIL drain_latency: valid=%b data=%0d required 1 5", bus.out_valid, bus.out_data);
      end
      drain(-1, 0);
   endtask

   task automatic test_multi_pass();
      logic [31:0] q[$];
      q = {32'd10, 32'd100, 32'd6, -32'sd20, 32'd4, 32'd0};
      start_job(2, 3, 2);
      feed_job(2, 3, 2, q, 2);
      drain(-1, 0);
   endtask

   task automatic test_backpressure();
      logic [31:0] q[$];
      q = {32'd40, -32'sd1, 32'd300, 32'd18, 32'd254, 32'd7};
      start_job(6, 1, 1);
      feed_job(6, 1, 1, q, 1);
      drain(2, 3);
   endtask

   task automatic test_ignored();
      int   vals [6] = '{11, 22, 33, 1, 2, 3};
      exp_t e;
      bus.in_valid = 1'b1; bus.inPartialSum = 32'd999;
      step();
      bus.in_valid = 1'b0;
      total++;
      if (bus.drop !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL drop_idle: drop=%b busy=%b required 1 0", bus.drop, bus.busy);
      end
      step();
      total++;
      if (bus.drop !== 1'b0) begin bad++; $display("FAIL drop_pulse: got %b required 0", bus.drop); end

      start_job(3, 2, 0);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 2) start_job(1, 1, 0);
         bus.in_valid = 1'b1; bus.inPartialSum = 32'(vals[k]);
         step();
         bus.in_valid = 1'b0;
         if (k == 0) begin
            total++;
            if (bus.drop !== 1'b0) begin bad++; $display("FAIL drop_accum: got %b required 0", bus.drop); end
         end
      end
      bus.in_valid = 1'b1; bus.inPartialSum = 32'd5000;
      step();
      bus.in_valid = 1'b0;
      total++;
      if (bus.drop !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'd12) begin
         bad++; $display("FAIL drop_drain: drop=%b valid=%b data=%0d required 1 1 12",
                         bus.drop, bus.out_valid, bus.out_data);
      end
      e.d = 8'd12; e.l = 1'b0; sb.push_back(e);
      e.d = 8'd24; e.l = 1'b0; sb.push_back(e);
      e.d = 8'd36; e.l = 1'b1; sb.push_back(e);
      drain(-1, 0);

      start_job(0, 1, 0);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b required 0", bus.busy); end
      start_job(17, 1, 0);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL len17_busy: got %b required 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q[$];
      start_job(4, 2, 0);
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1; bus.inPartialSum = 32'd1000;
         step();
         bus.in_valid = 1'b0;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
          bus.out_last !== 1'b0 || bus.done !== 1'b0 || bus.drop !== 1'b0) begin
         bad++; $display("FAIL mid_reset: busy=%b valid=%b data=%0d last=%b done=%b drop=%b required all 0",
                         bus.busy, bus.out_valid, bus.out_data, bus.out_last, bus.done, bus.drop);
      end
      q = {32'd9};
      start_job(1, 1, 0);
      feed_job(1, 1, 0, q, 0);
      drain(-1, 0);
   endtask

   task automatic test_wrap();
      logic [31:0] q[$];
      for (int i = 0; i < 16; i++) q.push_back((i == 15) ? 32'h7FFF_FFFF : 32'(i * 3));
      for (int i = 0; i < 16; i++) q.push_back((i == 15) ? 32'd1 : 32'(i));
      start_job(16, 2, 0);
      feed_job(16, 2, 0, q, 0);
      drain(-1, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      q = {32'd80, 32'd2000};
      start_job(2, 1, 3);
      feed_job(2, 1, 3, q, 0);
      drain(-1, 0);
      start_job(1, 1, 1);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_start: busy=%b required 1", bus.busy); end
      q = {32'd100};
      feed_job(1, 1, 1, q, 0);
      drain(-1, 0);
   endtask

   initial begin
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.cfg_len      = '0;
      bus.cfg_passes   = '0;
      bus.cfg_shift    = '0;
      bus.in_valid     = 1'b0;
      bus.inPartialSum = '0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_backpressure();
      test_ignored();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
